// File: rtl/pwm_meas_pkg.sv
// Shared constants and FSM state type for the PWM duty meter and the
// generator bench that drives it.
package pwm_meas_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int TIMEOUT_DEF     = 64;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int PWM_PERIOD      = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_STUCK_HI
  } meas_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM input into the clk domain and derives
// single-cycle rise/fall strobes from the synchronised level.
module pwm_sync_edge
  import pwm_meas_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign lvl  = sync_q[SYNC_STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of each complete PWM cycle in clk ticks and
// flags inputs stuck high or low for TIMEOUT cycles.
module pwm_duty_meter
  import pwm_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  logic lvl, rise, fall;
  logic edge_w, timeout_w;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
  logic [CNT_W-1:0] high_count_q, high_count_d;
  logic [CNT_W-1:0] period_count_q, period_count_d;
  logic             meas_valid_q, meas_valid_d;
  logic             stuck_high_q, stuck_high_d;
  logic             stuck_low_q, stuck_low_d;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .lvl   (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  // An edge arriving on the timeout cycle wins: timeout_w needs a quiet cycle.
  always_comb begin
    edge_w    = rise | fall;
    timeout_w = (run_q == TIMEOUT_C) && !edge_w;
    if (edge_w) begin
      run_d = ONE_C;
    end else if (run_q == TIMEOUT_C) begin
      run_d = run_q;
    end else begin
      run_d = run_q + ONE_C;
    end
  end

  always_comb begin
    state_d        = state_q;
    hi_cnt_d       = hi_cnt_q;
    lo_cnt_d       = lo_cnt_q;
    high_count_d   = high_count_q;
    period_count_d = period_count_q;
    meas_valid_d   = 1'b0;
    stuck_high_d   = stuck_high_q;
    stuck_low_d    = stuck_low_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d     = ST_HIGH;
          hi_cnt_d    = ONE_C;
          stuck_low_d = 1'b0;
        end else if (timeout_w && !lvl) begin
          stuck_low_d = 1'b1;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d  = ST_LOW;
          lo_cnt_d = ONE_C;
        end else if (timeout_w) begin
          state_d      = ST_STUCK_HI;
          stuck_high_d = 1'b1;
        end else begin
          hi_cnt_d = hi_cnt_q + ONE_C;
        end
      end
      ST_LOW: begin
        if (rise) begin
          high_count_d   = hi_cnt_q;
          period_count_d = hi_cnt_q + lo_cnt_q;
          meas_valid_d   = 1'b1;
          state_d        = ST_HIGH;
          hi_cnt_d       = ONE_C;
        end else if (timeout_w) begin
          // Partial period is dropped; the next rise starts a fresh one.
          state_d     = ST_IDLE;
          stuck_low_d = 1'b1;
        end else begin
          lo_cnt_d = lo_cnt_q + ONE_C;
        end
      end
      ST_STUCK_HI: begin
        if (fall) begin
          state_d      = ST_IDLE;
          stuck_high_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      run_q          <= ONE_C;
      hi_cnt_q       <= '0;
      lo_cnt_q       <= '0;
      high_count_q   <= '0;
      period_count_q <= '0;
      meas_valid_q   <= 1'b0;
      stuck_high_q   <= 1'b0;
      stuck_low_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      run_q          <= run_d;
      hi_cnt_q       <= hi_cnt_d;
      lo_cnt_q       <= lo_cnt_d;
      high_count_q   <= high_count_d;
      period_count_q <= period_count_d;
      meas_valid_q   <= meas_valid_d;
      stuck_high_q   <= stuck_high_d;
      stuck_low_q    <= stuck_low_d;
    end
  end

  assign high_count   = high_count_q;
  assign period_count = period_count_q;
  assign meas_valid   = meas_valid_q;
  assign stuck_high   = stuck_high_q;
  assign stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: table of PWM streams plus hand-written stuck,
// timeout-boundary and reset sequences, checked through an expected queue.
module tb_pwm_duty_meter;
  import pwm_meas_pkg::*;

  localparam int CNT_W       = CNT_W_DEF;
  localparam int TIMEOUT     = TIMEOUT_DEF;
  localparam int SYNC_STAGES = SYNC_STAGES_DEF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             pwm_in;
  logic [CNT_W-1:0] high_count;
  logic [CNT_W-1:0] period_count;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;

  pwm_duty_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .high_count  (high_count),
    .period_count(period_count),
    .meas_valid  (meas_valid),
    .stuck_high  (stuck_high),
    .stuck_low   (stuck_low)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [2*CNT_W-1:0] exp_q[$];
  int                 lat_q[$];

  bit have_prev;
  int prev_hi;
  int prev_per;
  bit saw_stuck_low;
  bit saw_stuck_high;

  typedef struct {
    int hi;
    int per;
    int reps;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_level(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  // The rise that starts this period closes the previous one.
  task automatic push_prev();
    logic [CNT_W-1:0] eh, ep;
    if (have_prev) begin
      eh = prev_hi[CNT_W-1:0];
      ep = prev_per[CNT_W-1:0];
      exp_q.push_back({eh, ep});
      lat_q.push_back(cyc);
    end
  endtask

  task automatic pwm_period(input int hi, input int per, input int exp_hi, input int exp_per);
    push_prev();
    drive_level(1'b1, hi);
    drive_level(1'b0, per - hi);
    have_prev = 1'b1;
    prev_hi   = exp_hi;
    prev_per  = exp_per;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_high_count"}, 32'(high_count), 0);
    check({tag, "_period_count"}, 32'(period_count), 0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 0);
    check({tag, "_stuck_high"}, 32'(stuck_high), 0);
    check({tag, "_stuck_low"}, 32'(stuck_low), 0);
  endtask

  // ---------------- monitor ----------------
  logic [2*CNT_W-1:0] mon_e;
  int                 mon_l;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stuck_low === 1'b1) saw_stuck_low = 1'b1;
      if (stuck_high === 1'b1) saw_stuck_high = 1'b1;
      if (meas_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid=%b high=%0d period=%0d, expected no valid (cycle %0d)",
                   meas_valid, high_count, period_count, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          check("high_count", 32'(high_count), 32'(mon_e[2*CNT_W-1:CNT_W]));
          check("period_count", 32'(period_count), 32'(mon_e[CNT_W-1:0]));
          check("valid_latency", cyc - mon_l, SYNC_STAGES + 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{hi: 5, per: 10, reps: 4, exp_hi: 5, exp_per: 10};
    vecs[1] = '{hi: 6, per: 10, reps: 3, exp_hi: 6, exp_per: 10};
    vecs[2] = '{hi: 1, per: 10, reps: 3, exp_hi: 1, exp_per: 10};
    vecs[3] = '{hi: 9, per: 10, reps: 2, exp_hi: 9, exp_per: 10};
    vecs[4] = '{hi: 1, per: 2,  reps: 3, exp_hi: 1, exp_per: 2};
    vecs[5] = '{hi: 2, per: 66, reps: 2, exp_hi: 2, exp_per: 66};
    vecs[6] = '{hi: 3, per: 7,  reps: 2, exp_hi: 3, exp_per: 7};

    have_prev      = 1'b0;
    prev_hi        = 0;
    prev_per       = 0;
    saw_stuck_low  = 1'b0;
    saw_stuck_high = 1'b0;
    rst_n          = 1'b0;
    pwm_in         = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    drive_level(1'b0, 3);

    // Table-driven streams, including a period with exactly TIMEOUT low cycles.
    for (int v = 0; v < 7; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        pwm_period(vecs[v].hi, vecs[v].per, vecs[v].exp_hi, vecs[v].exp_per);
      end
    end
    check("table_no_stuck_low", 32'(saw_stuck_low), 0);
    check("table_no_stuck_high", 32'(saw_stuck_high), 0);

    // 0% duty: the open period is discarded.
    drive_level(1'b0, 80);
    have_prev = 1'b0;
    check("hold_low_stuck_low", 32'(stuck_low), 1);
    check("hold_low_stuck_high", 32'(stuck_high), 0);
    check("hold_low_pending", exp_q.size(), 0);
    pwm_period(3, 10, 3, 10);
    check("resume_stuck_low_clear", 32'(stuck_low), 0);
    pwm_period(3, 10, 3, 10);
    pwm_period(3, 10, 3, 10);

    // TIMEOUT+1 low cycles before the rise: stuck_low pulses, period dropped.
    saw_stuck_low = 1'b0;
    pwm_period(2, 2 + TIMEOUT + 1, 2, 2 + TIMEOUT + 1);
    have_prev = 1'b0;
    pwm_period(3, 10, 3, 10);
    check("timeout_plus1_stuck_low_seen", 32'(saw_stuck_low), 1);
    check("timeout_plus1_stuck_low_clear", 32'(stuck_low), 0);
    pwm_period(3, 10, 3, 10);

    // 100% duty.
    push_prev();
    drive_level(1'b1, 80);
    have_prev = 1'b0;
    check("hold_high_stuck_high", 32'(stuck_high), 1);
    check("hold_high_stuck_low", 32'(stuck_low), 0);
    drive_level(1'b0, 5);
    check("drop_low_stuck_high_clear", 32'(stuck_high), 0);
    check("drop_low_pending", exp_q.size(), 0);
    pwm_period(4, 10, 4, 10);
    pwm_period(4, 10, 4, 10);
    pwm_period(7, 10, 7, 10);

    // Reset pulse inside a high phase of a 7/10 stream.
    push_prev();
    pwm_in = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    have_prev = 1'b0;
    check("mid_reset_pending", exp_q.size(), 0);
    drive_level(1'b0, 3);
    pwm_period(7, 10, 7, 10);
    check("post_reset_no_early_valid", exp_q.size(), 0);
    pwm_period(7, 10, 7, 10);
    pwm_period(5, 10, 5, 10);

    repeat (20) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
